param_sync_fifo: RTL and testbench

//  Parametrised single-clock FIFO for interconnect channel buffering (AXI/OCP request, data, response).

---
 rtl/param_sync_fifo.sv | 146 ++++++++++++++
 tb/tb_param_sync_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO for interconnect channel buffering.
// Selectable read mode (first-word-fall-through or registered), occupancy
// count, programmable almost-full/almost-empty flags and overflow/underflow
// error pulses. All status flags are registered from the next occupancy so
// they line up with count in the same cycle.
module param_sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       re,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] AF_C    = AF_THRESH[AW:0];
  localparam logic [AW:0] AE_C    = AE_THRESH[AW:0];
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        af_q, af_d;
  logic        ae_q, ae_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic        wr_en, rd_en;

  // Accept decisions use the flags as registered before the edge.
  always_comb begin
    wr_en = we && !full_q;
    rd_en = re && !empty_q;
  end

  // Next pointers, occupancy, flags and error pulses.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + ONE_C;
    if (rd_en) rptr_d = rptr_q + ONE_C;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    ovf_d   = we && full_q;
    udf_d   = re && empty_q;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= (AF_C == '0);
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage write; the array is deliberately not reset, and writes in the
  // reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word presented combinationally; zero while empty.
    always_comb begin
      rdata = '0;
      if (!empty_q) rdata = mem_q[rptr_q[AW-1:0]];
    end
    assign rvalid = !empty_q;
  end else begin : g_reg
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    // Registered read: load head on an accepted pop, otherwise hold.
    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rd_en;
      if (rd_en) rdata_d = mem_q[rptr_q[AW-1:0]];
    end

    // Read data register with synchronous reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: one FWFT and one registered-read
// instance share stimulus; a queue-based reference model predicts data and
// post-edge status, and independent monitors compare the DUT outputs.
module tb_param_sync_fifo;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst, we, re;
  logic [W-1:0] wdata;

  logic [W-1:0] rdata1, rdata0;
  logic         rvalid1, rvalid0;
  logic         full1, empty1, af1, ae1, ovf1, udf1;
  logic         full0, empty0, af0, ae0, ovf0, udf0;
  logic [3:0]   count1, count0;

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut (
    .clk(clk), .rst(rst), .we(we), .wdata(wdata), .re(re),
    .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1));

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut_r (
    .clk(clk), .rst(rst), .we(we), .wdata(wdata), .re(re),
    .rdata(rdata0), .rvalid(rvalid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0));

  always #5 clk = ~clk;

  typedef struct {
    int           cnt;
    bit           full, empty, af, ae, ovf, udf, rv1, rv0;
    logic [W-1:0] rd1, rd0;
  } st_t;

  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_fwft[$];
  logic [W-1:0] exp_reg[$];
  st_t          st_q[$];
  logic [W-1:0] hold0 = '0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts the effect of the coming edge.
  task automatic cycle(input bit r, input bit w, input logic [W-1:0] d, input bit rd);
    st_t s;
    bit  wacc, racc, was_full, was_empty;
    logic [W-1:0] popped;
    rst = r; we = w; wdata = d; re = rd;
    was_full  = (model_q.size() == D);
    was_empty = (model_q.size() == 0);
    popped = '0;
    if (r) begin
      model_q.delete();
      hold0 = '0;
      s.ovf = 0; s.udf = 0; s.rv0 = 0;
    end else begin
      wacc = w && !was_full;
      racc = rd && !was_empty;
      if (racc) begin
        popped = model_q.pop_front();
        exp_fwft.push_back(popped);
        exp_reg.push_back(popped);
        hold0 = popped;
      end
      if (wacc) model_q.push_back(d);
      s.ovf = w && was_full;
      s.udf = rd && was_empty;
      s.rv0 = racc;
    end
    s.cnt   = model_q.size();
    s.full  = (s.cnt == D);
    s.empty = (s.cnt == 0);
    s.af    = (s.cnt >= AF);
    s.ae    = (s.cnt <= AE);
    s.rv1   = !s.empty;
    s.rd1   = s.empty ? '0 : model_q[0];
    s.rd0   = hold0;
    st_q.push_back(s);
    @(posedge clk);
    #2;
  endtask

  // Status monitor: expectation for an edge is taken at that edge, compared
  // half a cycle later.
  initial begin
    st_t cur;
    forever begin
      @(posedge clk);
      if (st_q.size() != 0) begin
        cur = st_q.pop_front();
        @(negedge clk);
        chk("count",        32'(count1), 32'(cur.cnt));
        chk("count_r",      32'(count0), 32'(cur.cnt));
        chk("full",         32'(full1),  32'(cur.full));
        chk("empty",        32'(empty1), 32'(cur.empty));
        chk("almost_full",  32'(af1),    32'(cur.af));
        chk("almost_empty", 32'(ae1),    32'(cur.ae));
        chk("overflow",     32'(ovf1),   32'(cur.ovf));
        chk("underflow",    32'(udf1),   32'(cur.udf));
        chk("flags_r",      32'({full0, empty0, af0, ae0, ovf0, udf0}),
            32'({cur.full, cur.empty, cur.af, cur.ae, cur.ovf, cur.udf}));
        chk("rvalid_fwft",  32'(rvalid1), 32'(cur.rv1));
        chk("rdata_fwft",   32'(rdata1),  32'(cur.rd1));
        chk("rvalid_reg",   32'(rvalid0), 32'(cur.rv0));
        chk("rdata_reg",    32'(rdata0),  32'(cur.rd0));
      end
    end
  end

  // FWFT data monitor: a word is consumed whenever the DUT shows valid data
  // and a pop is being requested.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rvalid1 === 1'b1 && re === 1'b1 && rst === 1'b0) begin
        if (exp_fwft.size() == 0) chk("fwft_pop_unexpected", 32'(rdata1), 32'hFFFF_FFFF);
        else begin
          e = exp_fwft.pop_front();
          chk("fwft_pop_data", 32'(rdata1), 32'(e));
        end
      end
    end
  end

  // Registered-read data monitor: each rvalid pulse consumes one word.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rvalid0 === 1'b1) begin
        if (exp_reg.size() == 0) chk("reg_pop_unexpected", 32'(rdata0), 32'hFFFF_FFFF);
        else begin
          e = exp_reg.pop_front();
          chk("reg_pop_data", 32'(rdata0), 32'(e));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; wdata = '0;
    cycle(1, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 0);
    // Fill with A0..A7, then overflow attempt.
    for (int i = 0; i < 8; i++) cycle(0, 1, 8'hA0 + 8'(i), 0);
    cycle(0, 1, 8'hFF, 0);
    cycle(0, 0, 8'h00, 0);
    // Full with simultaneous we+re: pop only.
    cycle(0, 1, 8'hEE, 1);
    cycle(0, 1, 8'hA0, 0);
    // Drain, then underflow.
    for (int i = 0; i < 8; i++) cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 1, 8'h5A, 1);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 0);
    // Steady state at count 3 with pointer wrap.
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'h30 + 8'(i), 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 8'($urandom), 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1);
    // Registered-read sequence.
    cycle(0, 1, 8'h11, 0);
    cycle(0, 1, 8'h22, 0);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    // Reset mid-operation with requests present in the reset cycle.
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'h50 + 8'(i), 0);
    cycle(1, 1, 8'h77, 1);
    cycle(0, 1, 8'h66, 0);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 0);
    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      bit r, w, rd;
      r  = ($urandom_range(0, 79) == 0);
      w  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
      rd = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
      cycle(r, w, 8'($urandom), rd);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 0);
    @(negedge clk);
    #1;
    chk("fwft_queue_drained", 32'(exp_fwft.size()), 32'd0);
    chk("reg_queue_drained",  32'(exp_reg.size()),  32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
